// File: rtl/pipeline_sink_if.sv
// Upstream byte handshake between the last pipeline stage and the sink.
interface pipeline_sink_if #(
    parameter int WIDTH = 8
);
    logic             DIR;
    logic [WIDTH-1:0] data_in;
    logic             ack;

    modport master (output DIR, output data_in, input ack);
    modport slave  (input DIR, input data_in, output ack);
endinterface

// File: rtl/pipeline_sink.sv
// Terminal consumer of the byte pipeline: four-phase handshake into a
// show-ahead FIFO, with running byte count, XOR checksum and sticky underflow.
module pipeline_sink #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    pipeline_sink_if.slave   up,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic [15:0]      byte_count,
    output logic [WIDTH-1:0] checksum,
    output logic             underflow
);
    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    state_t           state_q;
    state_t           state_d;
    logic             wr_en;
    logic             pop;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Status flags come only from the registered occupancy, so a same-cycle
    // pop never unblocks a write on that edge.
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    // ack is simply the registered ACK state.
    assign up.ack  = (state_q == ACK);

    // Handshake next-state: capture once in IDLE, then wait for DIR to drop.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (up.DIR && !full) begin
                    wr_en   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!up.DIR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage is not reset; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= up.data_in;
        end
    end

    // Pointers, occupancy, statistics and sticky underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            byte_count <= '0;
            checksum   <= '0;
            underflow  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr     <= wr_ptr + AW'(1);
                byte_count <= byte_count + 16'd1;
                checksum   <= checksum ^ up.data_in;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_sink.sv
// Self-checking bench for pipeline_sink: table-driven handshakes plus
// hand-written corner sequences, with a FIFO-order scoreboard.
module tb_pipeline_sink;
    logic        clk;
    logic        reset;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic [15:0] byte_count;
    logic [7:0]  checksum;
    logic        underflow;

    pipeline_sink_if #(.WIDTH(8)) up_if ();

    pipeline_sink #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .up         (up_if.slave),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .byte_count (byte_count),
        .checksum   (checksum),
        .underflow  (underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  sb [$];
    logic [15:0] exp_bc;
    logic [7:0]  exp_cs;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] exp_bc;
        logic [7:0]  exp_cs;
        logic [3:0]  exp_count;
    } vec_t;

    vec_t vecs [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        up_if.DIR   = 1'b0;
        up_if.data_in = 8'h00;
        rd_en       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        exp_bc = '0;
        exp_cs = '0;
    endtask

    // Full four-phase handshake of one byte; bounded wait on ack.
    task automatic handshake(input string name, input logic [7:0] d);
        int w;
        up_if.DIR     = 1'b1;
        up_if.data_in = d;
        w = 0;
        do begin
            tick();
            w++;
        end while (!up_if.ack && w < 40);
        check({name, "_ack_rise"}, up_if.ack, 1);
        if (up_if.ack) begin
            sb.push_back(d);
            exp_bc = exp_bc + 16'd1;
            exp_cs = exp_cs ^ d;
        end
        up_if.DIR     = 1'b0;
        up_if.data_in = 8'hxx;
        tick();
        check({name, "_ack_fall"}, up_if.ack, 0);
    endtask

    // Pop one entry, comparing the show-ahead head with the scoreboard.
    task automatic pop_check(input string name);
        logic [7:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        check({name, "_notempty"}, empty, 0);
        check({name, "_rd_data"}, rd_data, e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{data: 8'h3C, exp_bc: 16'd1, exp_cs: 8'h3C, exp_count: 4'd1};
        vecs[1] = '{data: 8'hC3, exp_bc: 16'd2, exp_cs: 8'hFF, exp_count: 4'd2};
        vecs[2] = '{data: 8'h0F, exp_bc: 16'd3, exp_cs: 8'hF0, exp_count: 4'd3};
        vecs[3] = '{data: 8'hF0, exp_bc: 16'd4, exp_cs: 8'h00, exp_count: 4'd4};

        // Reset state
        do_reset();
        check("rst_ack", up_if.ack, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_bc", byte_count, 0);
        check("rst_cs", checksum, 0);
        check("rst_uf", underflow, 0);

        // Single byte with exact ack timing
        up_if.DIR = 1'b1;
        up_if.data_in = 8'hA5;
        tick();
        check("single_ack_rise", up_if.ack, 1);
        up_if.DIR = 1'b0;
        up_if.data_in = 8'h00;
        tick();
        check("single_ack_fall", up_if.ack, 0);
        check("single_count", count, 1);
        check("single_rd_data", rd_data, 8'hA5);
        check("single_bc", byte_count, 1);
        check("single_cs", checksum, 8'hA5);

        // Table-driven handshakes
        do_reset();
        for (int i = 0; i < 4; i++) begin
            handshake("tbl", vecs[i].data);
            check("tbl_bc", byte_count, vecs[i].exp_bc);
            check("tbl_cs", checksum, vecs[i].exp_cs);
            check("tbl_count", count, vecs[i].exp_count);
        end
        for (int i = 0; i < 4; i++) pop_check("tbl_drain");
        check("tbl_empty", empty, 1);

        // Back-pressure
        do_reset();
        for (int i = 1; i <= 8; i++) handshake("bp_fill", 8'(i));
        check("bp_full", full, 1);
        check("bp_count8", count, 8);
        up_if.DIR = 1'b1;
        up_if.data_in = 8'h09;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_ack_held_low", up_if.ack, 0);
            check("bp_full_held", full, 1);
        end
        pop_check("bp_pop");
        check("bp_ack_after_pop", up_if.ack, 0);
        check("bp_count_after_pop", count, 7);
        tick();
        check("bp_ack_late", up_if.ack, 1);
        check("bp_count_refill", count, 8);
        sb.push_back(8'h09);
        up_if.DIR = 1'b0;
        tick();
        check("bp_ack_fall", up_if.ack, 0);
        for (int i = 0; i < 8; i++) pop_check("bp_drain");
        check("bp_empty", empty, 1);
        check("bp_bc", byte_count, 9);

        // Simultaneous write and pop at count=3
        do_reset();
        handshake("sim_fill", 8'h10);
        handshake("sim_fill", 8'h11);
        handshake("sim_fill", 8'h12);
        up_if.DIR = 1'b1;
        up_if.data_in = 8'h13;
        check("sim_head", rd_data, sb.pop_front());
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        sb.push_back(8'h13);
        check("sim_count", count, 3);
        check("sim_ack", up_if.ack, 1);
        up_if.DIR = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) pop_check("sim_drain");
        check("sim_empty", empty, 1);

        // Held DIR writes exactly one byte
        do_reset();
        up_if.DIR = 1'b1;
        up_if.data_in = 8'h55;
        tick();
        check("held_ack_rise", up_if.ack, 1);
        begin
            int highs = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (up_if.ack) highs++;
            end
            check("held_ack_cycles", highs, 10);
        end
        check("held_count", count, 1);
        check("held_bc", byte_count, 1);
        up_if.DIR = 1'b0;
        tick();
        check("held_ack_fall", up_if.ack, 0);
        check("held_rd_data", rd_data, 8'h55);

        // Underflow and pointer wrap
        do_reset();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("uf_set", underflow, 1);
        check("uf_count", count, 0);
        for (int i = 0; i < 20; i++) begin
            handshake("wrap", 8'hFF);
            if (i % 2 == 1) begin
                pop_check("wrap_pop");
                pop_check("wrap_pop");
            end
        end
        check("wrap_cs", checksum, 8'h00);
        check("wrap_bc", byte_count, 20);
        check("wrap_model_bc", byte_count, exp_bc);
        check("wrap_empty", empty, 1);
        check("wrap_uf_sticky", underflow, 1);

        // Reset while in ACK
        do_reset();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        up_if.DIR = 1'b1;
        up_if.data_in = 8'h77;
        tick();
        check("mid_ack_before", up_if.ack, 1);
        reset = 1'b1;
        tick();
        check("mid_ack", up_if.ack, 0);
        check("mid_count", count, 0);
        check("mid_bc", byte_count, 0);
        check("mid_cs", checksum, 0);
        check("mid_uf", underflow, 0);
        reset = 1'b0;
        up_if.DIR = 1'b0;
        sb.delete();
        exp_bc = '0;
        exp_cs = '0;
        tick();
        handshake("mid_after", 8'h5A);
        check("mid_after_bc", byte_count, exp_bc);
        check("mid_after_cs", checksum, exp_cs);
        pop_check("mid_after_pop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
